k6502_bus_trace: RTL and testbench



---
 rtl/k6502_bus_trace_pkg.sv | 33 +++
 rtl/k6502_trace_fifo.sv | 76 +++++++
 rtl/k6502_bus_trace.sv | 88 ++++++++
 tb/tb_k6502_bus_trace.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/k6502_bus_trace_pkg.sv
// Shared record layout and bus-cycle classification for the k6502 bus trace unit.
package k6502_bus_trace_pkg;

    localparam int unsigned TS_W   = 16;
    localparam int unsigned KIND_W = 2;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned REC_W  = TS_W + KIND_W + ADDR_W + DATA_W;

    typedef enum logic [KIND_W-1:0] {
        KIND_READ  = 2'b00,
        KIND_FETCH = 2'b01,
        KIND_WRITE = 2'b10
    } trace_kind_e;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        trace_kind_e       kind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } trace_rec_t;

    // A write wins over sync; otherwise sync marks an opcode fetch.
    function automatic trace_kind_e classify(input logic rw, input logic sync);
        if (rw)
            return KIND_WRITE;
        else if (sync)
            return KIND_FETCH;
        else
            return KIND_READ;
    endfunction

endpackage

// File: rtl/k6502_trace_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word;
// push and pop may happen together even when full.
module k6502_trace_fifo #(
    parameter int unsigned WIDTH = 42,
    parameter int unsigned DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               din,
    input  logic                           pop,
    output logic [WIDTH-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Head register tracks the word that will sit at rd_ptr after this edge.
    always_comb begin
        do_pop   = pop & ~empty_q;
        do_push  = push & (~full_q | do_pop);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
        full_d   = (level_d == LW'(DEPTH));
        empty_d  = (level_d == '0);
        head_d   = head_q;
        if (empty_d)
            head_d = '0;
        else if (empty_q || (do_pop && level_q == LW'(1)))
            head_d = din;
        else if (do_pop)
            head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= din;
    end

    assign dout  = head_q;
    assign level = level_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/k6502_bus_trace.sv
// Bus trace capture: classifies each k6502 bus cycle, timestamps qualifying
// ones into a FWFT FIFO, and latches halt/overflow status.
module k6502_bus_trace
    import k6502_bus_trace_pkg::*;
#(
    parameter int unsigned DEPTH         = 16,
    parameter bit          CAPTURE_READS = 1'b0,
    parameter logic [15:0] HALT_ADDR     = 16'hDEAD
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [15:0]                a,
    input  logic [7:0]                 d,
    input  logic                       rw,
    input  logic                       sync,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [41:0]                out_data,
    output logic                       halted,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    logic [TS_W-1:0] ts_q, ts_d;
    logic            halted_q, halted_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_count_q, drop_count_d;

    trace_rec_t      rec;
    logic            push, pop_eff, drop, halt_hit, qualifies;
    logic            fifo_full, fifo_empty;

    always_comb begin
        rec.ts    = ts_q;
        rec.kind  = classify(rw, sync);
        rec.addr  = a;
        rec.data  = d;
        qualifies = rw | sync | CAPTURE_READS;
        push      = en & ~halted_q & qualifies;
        pop_eff   = out_ready & ~fifo_empty;
        drop      = push & fifo_full & ~pop_eff;
        halt_hit  = en & ~halted_q & rw & (a == HALT_ADDR);

        ts_d         = ts_q + TS_W'(1);
        halted_d     = halted_q | halt_hit;
        overflow_d   = overflow_q | drop;
        drop_count_d = drop_count_q;
        if (drop && drop_count_q != 8'hFF)
            drop_count_d = drop_count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q         <= '0;
            halted_q     <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            ts_q         <= ts_d;
            halted_q     <= halted_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    k6502_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (rec),
        .pop   (out_ready),
        .dout  (out_data),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid  = ~fifo_empty;
    assign halted     = halted_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_k6502_bus_trace.sv
// Bench for k6502_bus_trace: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_k6502_bus_trace;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n, en, rw, sync, out_ready;
    logic [15:0]   a;
    logic [7:0]    d;
    logic          out_valid, halted, overflow;
    logic [41:0]   out_data;
    logic [7:0]    drop_count;
    logic [LW-1:0] level;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    k6502_bus_trace #(
        .DEPTH         (DEPTH),
        .CAPTURE_READS (1'b0),
        .HALT_ADDR     (16'hDEAD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .a          (a),
        .d          (d),
        .rw         (rw),
        .sync       (sync),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .halted     (halted),
        .overflow   (overflow),
        .drop_count (drop_count),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of records plus status scalars.
    logic [41:0] mq[$];
    int          m_ts;
    int          m_drops;
    bit          m_halt, m_ovf;
    logic [1:0]  m_kind;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_ts    = 0;
            m_drops = 0;
            m_halt  = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            if (out_ready && mq.size() > 0)
                void'(mq.pop_front());
            m_kind = rw ? 2'b10 : (sync ? 2'b01 : 2'b00);
            if (en && !m_halt && (rw || sync)) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back({m_ts[15:0], m_kind, a, d});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255)
                        m_drops++;
                end
            end
            if (en && !m_halt && rw && a == 16'hDEAD)
                m_halt = 1'b1;
            m_ts = (m_ts + 1) % 65536;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("cmp_data", 64'(out_data), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
            chk("cmp_level", 64'(level), 64'(mq.size()));
            chk("cmp_halted", 64'(halted), 64'(m_halt));
            chk("cmp_overflow", 64'(overflow), 64'(m_ovf));
            chk("cmp_drops", 64'(drop_count), 64'(m_drops));
        end
    end

    // Apply inputs for one edge; returns at the following negedge.
    task automatic drive(input logic e, input logic [15:0] aa, input logic [7:0] dd,
                         input logic w, input logic s, input logic r);
        en = e; a = aa; d = dd; rw = w; sync = s; out_ready = r;
        @(negedge clk);
    endtask

    task automatic idle(input logic r);
        drive(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1'b0);
        rst_n = 1'b1;
    endtask

    logic [41:0] exp1;
    logic [41:0] last;
    logic [41:0] first;

    initial begin
        rst_n = 1'b0; en = 1'b0; a = '0; d = '0; rw = 1'b0; sync = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);

        // First fetch at ts=3 lands on the head one cycle later.
        repeat (3) idle(1'b0);
        drive(1'b1, 16'h8000, 8'hA9, 1'b0, 1'b1, 1'b0);
        exp1 = {16'd3, 2'b01, 16'h8000, 8'hA9};
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'(exp1));

        // Write beats sync; plain reads are ignored.
        do_reset();
        drive(1'b1, 16'h0200, 8'h55, 1'b1, 1'b1, 1'b1);
        chk("t2_kind", 64'(out_data[25:24]), 64'd2);
        chk("t2_addr", 64'(out_data[23:8]), 64'h0200);
        chk("t2_level1", 64'(level), 64'd1);
        for (int i = 0; i < 5; i++)
            drive(1'b1, 16'(16'h0300 + i), 8'(i), 1'b0, 1'b0, 1'b1);
        chk("t2_level0", 64'(level), 64'd0);
        chk("t2_valid0", 64'(out_valid), 64'd0);

        // Overfill: 20 fetches into 16 slots.
        do_reset();
        for (int i = 0; i < 20; i++)
            drive(1'b1, 16'(16'h9000 + i), 8'(i), 1'b0, 1'b1, 1'b0);
        chk("t3_level", 64'(level), 64'd16);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_drops", 64'(drop_count), 64'd4);
        chk("t3_head", 64'(out_data[23:8]), 64'h9000);

        // Push with pop while full.
        drive(1'b1, 16'hA5A5, 8'h5A, 1'b0, 1'b1, 1'b1);
        chk("t4_level", 64'(level), 64'd16);
        chk("t4_ovf", 64'(overflow), 64'd1);
        chk("t4_drops", 64'(drop_count), 64'd4);
        first = out_data;
        last  = '0;
        for (int i = 0; i < 16; i++) begin
            last = out_data;
            idle(1'b1);
        end
        chk("t4_first", 64'(first[23:8]), 64'h9001);
        chk("t4_tail", 64'(last[23:8]), 64'hA5A5);
        chk("t4_empty", 64'(out_valid), 64'd0);

        // Terminate write then frozen capture, then reset clears everything.
        do_reset();
        drive(1'b1, 16'hDEAD, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t5_halted", 64'(halted), 64'd1);
        chk("t5_level", 64'(level), 64'd1);
        chk("t5_rec", 64'(out_data[25:8]), 64'({2'b10, 16'hDEAD}));
        for (int i = 0; i < 10; i++)
            drive(1'b1, 16'(16'h8100 + i), 8'h11, 1'b0, 1'b1, 1'b0);
        chk("t5_level_frozen", 64'(level), 64'd1);
        do_reset();
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_data", 64'(out_data), 64'd0);
        chk("t5_rst_level", 64'(level), 64'd0);
        chk("t5_rst_halted", 64'(halted), 64'd0);
        chk("t5_rst_ovf", 64'(overflow), 64'd0);
        chk("t5_rst_drops", 64'(drop_count), 64'd0);

        // Timestamp wrap: 70000 idle cycles, fetch sees 70000 mod 65536.
        for (int i = 0; i < 70000; i++)
            idle(1'b0);
        drive(1'b1, 16'hC000, 8'hEA, 1'b0, 1'b1, 1'b0);
        chk("t6_ts", 64'(out_data[41:26]), 64'd4464);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
